// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Moore sequencer for the shared-memory multicycle datapath. One micro-step
//   per state: fetch, decode, execute / memory address, memory access,
//   writeback. Control outputs decode from the state register and the opcode
//   latched in DECODE. The exceptions are the FETCH load enables, which follow
//   memReady, and the DECODE illegal pulse, which follows the live opcode.
//
//   Optional feature (macro SEQ_MEM_TIMEOUT_EN): a memory wait watchdog. After
//   TIMEOUT cycles without memReady in FETCH/MEMREAD/MEMWRITE it abandons the
//   access, sets the sticky timeoutErr flag and restarts at FETCH.
//
//   Ports
//     clock, resetN        rising-edge clock, asynchronous active-low reset
//     opcode[5:0]          ins[31:26] from the instruction register
//     memReady             memory finished the current access this cycle
//     PCWrite .. ALUControl datapath control strobes and mux selects
//     illegal              one-cycle pulse in DECODE for an unknown opcode
//     timeoutErr           sticky memory timeout (0 without the feature)
//     state[3:0]           current state, for debug
module multicycle_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       regWriteEnable,
  output logic       regDst,
  output logic       memToReg,
  output logic       linkWrite,
  output logic       branchEnable,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [4:0] ALUControl,
  output logic       illegal,
  output logic       timeoutErr,
  output logic [3:0] state
);

  // The counter must be able to hold TIMEOUT.
  if ((2 ** CW) <= TIMEOUT) begin : g_cw_chk
    $error("multicycle_sequencer: CW too narrow for TIMEOUT");
  end

  localparam logic [5:0] OP_AND  = 6'b100000;
  localparam logic [5:0] OP_NOR  = 6'b100110;
  localparam logic [5:0] OP_NOT  = 6'b000100;
  localparam logic [5:0] OP_ROLV = 6'b000000;
  localparam logic [5:0] OP_RORV = 6'b000010;
  localparam logic [5:0] OP_NORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BLEU = 6'b010000;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADDR  = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWRITE = 4'd5,
    S_MEMWB    = 4'd6,
    S_EXEC     = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_t;

  function automatic logic f_rtype(input logic [5:0] op);
    return (op == OP_AND) || (op == OP_NOR) || (op == OP_NOT) ||
           (op == OP_ROLV) || (op == OP_RORV);
  endfunction

  function automatic logic f_legal(input logic [5:0] op);
    return f_rtype(op) || (op == OP_NORI) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BLEU) || (op == OP_JR) || (op == OP_JAL);
  endfunction

  state_t     r_state;
  logic [5:0] r_op;
  logic       w_wait;   // sitting in a memory state without memReady
  logic       w_tmo;    // watchdog fires this cycle

  assign w_wait = ((r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                   (r_state == S_MEMWRITE)) && !memReady;

`ifdef SEQ_MEM_TIMEOUT_EN
  logic [CW-1:0] r_cnt;
  logic          r_tmo;

  // r_cnt counts wait cycles already spent; the TIMEOUT-th low cycle fires.
  // memReady in that cycle clears w_wait, so a late response still wins.
  assign w_tmo      = w_wait && (r_cnt == CW'(TIMEOUT - 1));
  assign timeoutErr = r_tmo;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      // Any non-waiting cycle (including the one before entry) clears it.
      r_cnt <= (w_wait && !w_tmo) ? r_cnt + 1'b1 : '0;
      r_tmo <= r_tmo | w_tmo;
    end
  end
`else
  assign w_tmo      = 1'b0;
  assign timeoutErr = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_op    <= '0;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  if (memReady) r_state <= S_DECODE;
        S_DECODE: begin
          r_op <= opcode;
          if ((opcode == OP_LW) || (opcode == OP_SW))          r_state <= S_MEMADDR;
          else if (f_rtype(opcode) || (opcode == OP_NORI))     r_state <= S_EXEC;
          else if (opcode == OP_BLEU)                          r_state <= S_BRANCH;
          else if ((opcode == OP_JR) || (opcode == OP_JAL))    r_state <= S_JUMP;
          else                                                 r_state <= S_FETCH;
        end
        // Only lw/sw reach MEMADDR.
        S_MEMADDR:  r_state <= (r_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (memReady) r_state <= S_MEMWB;
                    else if (w_tmo) r_state <= S_FETCH;
        S_MEMWRITE: if (memReady || w_tmo) r_state <= S_FETCH;
        S_EXEC:     r_state <= S_ALUWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: r_state <= S_FETCH;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    PCWrite        = 1'b0;
    IRWrite        = 1'b0;
    IorD           = 1'b0;
    memRead        = 1'b0;
    memWrite       = 1'b0;
    regWriteEnable = 1'b0;
    regDst         = 1'b0;
    memToReg       = 1'b0;
    linkWrite      = 1'b0;
    branchEnable   = 1'b0;
    ALUSrcA        = 1'b0;
    ALUSrcB        = 2'b00;
    PCSrc          = 2'b00;
    ALUControl     = 5'b00000;
    illegal        = 1'b0;
    case (r_state)
      S_FETCH: begin
        memRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = memReady;
        PCWrite = memReady;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        illegal = !f_legal(opcode);
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD: begin
        IorD    = 1'b1;
        memRead = 1'b1;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        memWrite = 1'b1;
      end
      S_MEMWB: begin
        regWriteEnable = 1'b1;
        memToReg       = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = (r_op == OP_NORI) ? 2'b10 : 2'b00;
        ALUControl = r_op[5:1];
      end
      S_ALUWB: begin
        regWriteEnable = 1'b1;
        regDst         = f_rtype(r_op);
        ALUControl     = r_op[5:1];
      end
      S_BRANCH: begin
        ALUSrcA      = 1'b1;
        branchEnable = 1'b1;
        PCSrc        = 2'b01;
        ALUControl   = 5'b01000;
      end
      S_JUMP: begin
        PCWrite        = 1'b1;
        PCSrc          = (r_op == OP_JAL) ? 2'b10 : 2'b11;
        regWriteEnable = (r_op == OP_JAL);
        linkWrite      = (r_op == OP_JAL);
      end
      default: ;
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer. Each instruction is expanded
// into the per-cycle list of expected outputs plus the memReady/opcode/resetN
// to drive. The driver pushes expectations as it drives, and a negedge monitor
// pops and compares them.
module tb_multicycle_sequencer;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic [5:0] opcode = '0;
  logic       memReady = 1'b0;
  logic       PCWrite, IRWrite, IorD, memRead, memWrite, regWriteEnable;
  logic       regDst, memToReg, linkWrite, branchEnable, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [4:0] ALUControl;
  logic       illegal, timeoutErr;
  logic [3:0] state;

  multicycle_sequencer dut (
    .clock(clock), .resetN(resetN), .opcode(opcode), .memReady(memReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .memRead(memRead),
    .memWrite(memWrite), .regWriteEnable(regWriteEnable), .regDst(regDst),
    .memToReg(memToReg), .linkWrite(linkWrite), .branchEnable(branchEnable),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUControl(ALUControl), .illegal(illegal), .timeoutErr(timeoutErr),
    .state(state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       pcw, irw, iord, mrd, mwr, rwe, rdst, m2r, lnk, br, asa;
    logic [1:0] asb, pcs;
    logic [4:0] aluc;
    logic       ill, tmo;
    logic [3:0] st;
  } obs_t;

  typedef struct {
    obs_t       o;
    logic       rdy;
    logic [5:0] op;
    logic       rstn;
  } step_t;

  step_t steps[$];
  obs_t  exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  obs_t got;
  assign got = '{PCWrite, IRWrite, IorD, memRead, memWrite, regWriteEnable,
                 regDst, memToReg, linkWrite, branchEnable, ALUSrcA, ALUSrcB,
                 PCSrc, ALUControl, illegal, timeoutErr, state};

  // Legal opcode groups.
  logic [5:0] rtype_ops[5] = '{6'b100000, 6'b100110, 6'b000100, 6'b000000, 6'b000010};
  localparam logic [5:0] NORI = 6'b001110, LW = 6'b100011, SW = 6'b101011,
                         BLEU = 6'b010000, JR = 6'b001000, JAL = 6'b000011;

  function automatic bit is_rt(logic [5:0] op);
    foreach (rtype_ops[i]) if (rtype_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    return is_rt(op) || op inside {NORI, LW, SW, BLEU, JR, JAL};
  endfunction

  function automatic obs_t z(logic [3:0] st);
    obs_t o = '0;
    o.st = st;
    return o;
  endfunction

  // rdy/op don't-care cycles get random values to show they are ignored.
  task automatic add(obs_t o, logic rdy, logic [5:0] op, logic rstn);
    step_t s;
    s.o = o; s.rdy = rdy; s.op = op; s.rstn = rstn;
    steps.push_back(s);
  endtask

  task automatic add_x(obs_t o);
    add(o, 1'($urandom), 6'($urandom), 1'b1);
  endtask

  // Expected behaviour of one instruction: fw fetch stalls, mw memory stalls.
  task automatic gen_instr(logic [5:0] op, int fw, int mw);
    obs_t o;
    o = z(1); o.mrd = 1; o.asb = 2'b01;
    repeat (fw) add(o, 1'b0, 6'($urandom), 1'b1);
    o.irw = 1; o.pcw = 1;
    add(o, 1'b1, 6'($urandom), 1'b1);
    o = z(2); o.asb = 2'b11; o.ill = !is_legal(op);
    add(o, 1'($urandom), op, 1'b1);
    if (op == LW || op == SW) begin
      o = z(3); o.asa = 1; o.asb = 2'b10; add_x(o);
      if (op == LW) begin o = z(4); o.iord = 1; o.mrd = 1; end
      else          begin o = z(5); o.iord = 1; o.mwr = 1; end
      repeat (mw) add(o, 1'b0, 6'($urandom), 1'b1);
      add(o, 1'b1, 6'($urandom), 1'b1);
      if (op == LW) begin o = z(6); o.rwe = 1; o.m2r = 1; add_x(o); end
    end else if (is_rt(op) || op == NORI) begin
      o = z(7); o.asa = 1; o.asb = (op == NORI) ? 2'b10 : 2'b00; o.aluc = op[5:1];
      add_x(o);
      o = z(8); o.rwe = 1; o.rdst = (op != NORI); o.aluc = op[5:1];
      add_x(o);
    end else if (op == BLEU) begin
      o = z(9); o.asa = 1; o.br = 1; o.pcs = 2'b01; o.aluc = 5'b01000;
      add_x(o);
    end else if (op == JR || op == JAL) begin
      o = z(10); o.pcw = 1; o.pcs = (op == JAL) ? 2'b10 : 2'b11;
      o.rwe = (op == JAL); o.lnk = (op == JAL);
      add_x(o);
    end
  endtask

  // lw interrupted by reset while waiting in MEMREAD.
  task automatic gen_lw_reset(int waits);
    obs_t o;
    o = z(1); o.mrd = 1; o.asb = 2'b01; o.irw = 1; o.pcw = 1;
    add(o, 1'b1, 6'($urandom), 1'b1);
    o = z(2); o.asb = 2'b11; add(o, 1'b1, LW, 1'b1);
    o = z(3); o.asa = 1; o.asb = 2'b10; add_x(o);
    o = z(4); o.iord = 1; o.mrd = 1;
    repeat (waits) add(o, 1'b0, 6'($urandom), 1'b1);
    add(z(0), 1'b1, 6'($urandom), 1'b0);   // everything drops at once
    add(z(0), 1'b1, 6'($urandom), 1'b1);   // released: still IDLE this cycle
  endtask

  task automatic check(string name, obs_t g, obs_t e);
    n_vec++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s: got %h (state %0d) want %h (state %0d)", name, g, g.st, e, e.st);
    end
  endtask

  // Monitor: compare whatever the driver expects for this cycle.
  initial begin
    obs_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("cycle", got, e);
      end
    end
  end

  initial begin
    logic [5:0] pool[12] = '{6'b100000, 6'b100110, 6'b000100, 6'b000000, 6'b000010,
                             NORI, LW, SW, BLEU, JR, JAL, 6'b111111};
    logic [5:0] op;
    int         k;

    // Reset held, then released: two IDLE cycles, then instructions.
    add(z(0), 1'b1, 6'($urandom), 1'b0);
    add(z(0), 1'b1, 6'($urandom), 1'b0);
    add(z(0), 1'b1, 6'($urandom), 1'b1);
    // Directed scenarios from the plan.
    gen_instr(LW, 0, 0);
    gen_instr(SW, 0, 3);
    gen_instr(6'b100110, 0, 0);
    gen_instr(NORI, 1, 0);
    gen_instr(JAL, 0, 0);
    gen_instr(JR, 2, 0);
    gen_instr(6'b111111, 0, 0);
    gen_lw_reset(2);
    gen_instr(BLEU, 0, 0);
    // Random mix, including random (possibly illegal) opcodes.
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 15);
      op = (k < 12) ? pool[k] : 6'($urandom);
      gen_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 20) == 0) gen_lw_reset($urandom_range(0, 3));
    end

    foreach (steps[i]) begin
      @(posedge clock);
      #1;
      resetN   = steps[i].rstn;
      memReady = steps[i].rdy;
      opcode   = steps[i].op;
      exp_q.push_back(steps[i].o);
    end

    k = 0;
    while (exp_q.size() != 0 && k < 10) begin
      @(posedge clock);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Moore FSM that sequences the shared-memory multicycle datapath: fetch, decode, execute, memory access and writeback, one micro-step per state.
- Replaces the per-instruction ad-hoc two-cycle lw/sw latching with a single explicit state register.
- Adds a ready handshake to the unified instruction/data memory.
- Sits between the instruction register and the datapath muxes, register file and memory.

Parameters:
- TIMEOUT, 15, maximum cycles spent waiting for memReady in one memory state (used only with the optional feature).
- CW, 4, width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- opcode  in  6  ins[31:26] from the instruction register.
- memReady  in  1  memory completed the current read/write this cycle.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  instruction register load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memRead  out  1  memory read strobe.
- memWrite  out  1  memory write strobe.
- regWriteEnable  out  1  register-file write enable.
- regDst  out  1  destination register select: 1 = rd, 0 = rt.
- memToReg  out  1  writeback data from memory data register.
- linkWrite  out  1  writeback data is PC (jal).
- branchEnable  out  1  conditional PC load on bleu.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B input: 00 = register B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- PCSrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register (jr).
- ALUControl  out  5  ALU operation select.
- illegal  out  1  one-cycle pulse on an undecodable opcode.
- timeoutErr  out  1  sticky memory timeout flag (optional feature only).
- state  out  4  current state, for debug.

Behaviour:
- Opcode decode:
  - and 100000, nor 100110, not 000100, rolv 000000, rorv 000010: R-type.
  - nori 001110; lw 100011; sw 101011; bleu 010000; jr 001000; jal 000011.
- States: IDLE 0, FETCH 1, DECODE 2, MEMADDR 3, MEMREAD 4, MEMWRITE 5, MEMWB 6, EXEC 7, ALUWB 8, BRANCH 9, JUMP 10.
- Reset: state = IDLE, latched opcode = 0. All outputs, including state, are 0 while in IDLE.
- IDLE: go to FETCH unconditionally on the first clock after resetN deasserts.
- Unlisted outputs are 0 in every state. Outputs are decoded combinationally from the state register and latched opcode only; no combinational path from memReady except where stated below.
- FETCH:
  - Outputs: memRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, PCSrc=00; IRWrite=PCWrite=memReady.
  - Stay while memReady=0; go to DECODE when memReady=1.
- DECODE:
  - Latch opcode. Outputs: ALUSrcA=0, ALUSrcB=11 (branch target precompute).
  - Next state: lw/sw -> MEMADDR; R-type/nori -> EXEC; bleu -> BRANCH; jr/jal -> JUMP.
  - Any other opcode: illegal=1 this cycle, then FETCH.
- MEMADDR: ALUSrcA=1, ALUSrcB=10. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: IorD=1, memRead=1. Stay until memReady=1, then MEMWB.
- MEMWRITE: IorD=1, memWrite=1. Stay until memReady=1, then FETCH. memWrite stays high for the whole wait.
- MEMWB: regWriteEnable=1, memToReg=1, regDst=0, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=10 for nori, 00 otherwise; ALUControl = latched opcode[5:1]. Then ALUWB.
- ALUWB: regWriteEnable=1, regDst=1 for R-type, 0 for nori; ALUControl held. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, branchEnable=1, PCSrc=01, ALUControl=01000. Then FETCH.
- JUMP:
  - PCWrite=1; PCSrc=11 for jr, 10 for jal.
  - jal also sets regWriteEnable=1 and linkWrite=1.
  - Then FETCH.
- Latency in cycles including fetch, with memReady high on first request:
  - lw 5; sw 4; R-type/nori 4; bleu 3; jr/jal 3.
  - Each extra memReady-low cycle adds 1.
- memReady is ignored outside FETCH, MEMREAD and MEMWRITE.
- opcode is ignored outside DECODE.
- Reset mid-instruction: forced to IDLE asynchronously, all strobes drop immediately, no partial writeback.

Optional Feature:
- Macro: SEQ_MEM_TIMEOUT_EN.
- Defined:
  - CW-bit counter clears on entry to FETCH, MEMREAD and MEMWRITE, and increments each cycle spent waiting there.
  - When it reaches TIMEOUT with memReady=0: set timeoutErr (sticky until reset), abandon the access, go to FETCH. An abandoned FETCH re-issues the fetch of the same PC.
  - memReady arriving in the same cycle the count reaches TIMEOUT wins; no error is raised.
- Undefined: no counter, timeoutErr tied 0, states wait indefinitely.

Test Plan:
- Reset, then release with memReady=1, opcode 100011 (lw): state sequence 1,2,3,4,6,1; IorD=1 only in state 4; regWriteEnable=memToReg=1 only in state 6.
- sw (101011) with memReady low 3 cycles in MEMWRITE: memWrite high for exactly 4 consecutive cycles, then FETCH; regWriteEnable never asserted.
- R-type 100110 (nor): EXEC shows ALUControl=10011, ALUSrcB=00; ALUWB shows regWriteEnable=1, regDst=1. nori 001110: ALUSrcB=10, regDst=0.
- jal 000011: JUMP state shows PCWrite=1, PCSrc=10, regWriteEnable=1, linkWrite=1. jr 001000: PCSrc=11, regWriteEnable=0. Opcode 111111: illegal pulse for 1 cycle, then FETCH.
- resetN low during MEMREAD: all outputs 0 in the same cycle, state=0; after release, FETCH on the next clock.
- With SEQ_MEM_TIMEOUT_EN, TIMEOUT=15, memReady stuck 0 in MEMREAD: timeoutErr rises after 15 wait cycles, state returns to 1, and timeoutErr stays 1 until reset.
